aurora_ordered_set_detector: RTL and testbench

Receive-side counterpart of the lane transmit path. It consumes one 8B/10B-decoded character per cycle, with its K flag, from the lane decoder. It recognises the Aurora ordered sets SP, SPA, VER, SCP, ECP, CC, K, R, A, P_SUF and SNF, and reports each one as an ordered_sets_e code. Data characters outside an ordered set pass through to the lane deframer.

---
 rtl/aurora_ordered_set_detector.sv | 168 ++++++++++++++++
 tb/tb_aurora_ordered_set_detector.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_ordered_set_detector.sv
// Receive-side Aurora ordered-set recogniser: turns one decoded 8B/10B character per cycle
// into an ordered-set code, a pass-through data character, or a protocol-error pulse.
`ifndef ENCODER_DATA_IN_SIZE
`define ENCODER_DATA_IN_SIZE 8
`endif
`ifndef ORDERED_SEQUENCE_SIZE
`define ORDERED_SEQUENCE_SIZE 32
`endif

module aurora_ordered_set_detector #(
  parameter int DATA_SIZE = `ENCODER_DATA_IN_SIZE,
  parameter int ERR_CNT_W = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx_valid,
  input  logic [DATA_SIZE-1:0]              rx_data,
  input  logic                              rx_is_k,
  input  logic                              rx_code_err,
  output logic                              os_valid,
  output logic [`ORDERED_SEQUENCE_SIZE-1:0] os_type,
  output logic                              data_valid,
  output logic [DATA_SIZE-1:0]              data_out,
  output logic                              os_err,
  output logic [ERR_CNT_W-1:0]              err_cnt
);
  // Code value = wire characters packed little-endian (first character in the LSB byte).
  typedef enum logic [`ORDERED_SEQUENCE_SIZE-1:0] {
    NONE  = 32'h0000_0000,
    SP    = 32'h4A4A_4ABC,
    SPA   = 32'h2C2C_2CBC,
    VER   = 32'hE8E8_E8BC,
    SCP   = 32'h0000_FB5C,
    ECP   = 32'h0000_FEFD,
    CC    = 32'h0000_F7F7,
    K     = 32'h0000_00BC,
    R     = 32'h0000_001C,
    A     = 32'h0000_007C,
    P_SUF = 32'h0000_009C,
    SNF   = 32'h0000_00DC
  } ordered_sets_e;

  typedef enum logic [2:0] {
    IDLE, GOT_K28_5, COLLECT1, COLLECT2, GOT_SCP1, GOT_ECP1, GOT_CC1
  } state_e;

  localparam logic [7:0] K28_5 = 8'hBC, D10_2 = 8'h4A, D12_1 = 8'h2C, D08_7 = 8'hE8;
  localparam logic [7:0] K28_2 = 8'h5C, K27_7 = 8'hFB, K29_7 = 8'hFD, K30_7 = 8'hFE;
  localparam logic [7:0] K23_7 = 8'hF7, K28_4 = 8'h9C, K28_0 = 8'h1C, K28_3 = 8'h7C;
  localparam logic [7:0] K28_6 = 8'hDC;

  state_e               state, state_n;
  logic [DATA_SIZE-1:0] coll, coll_n;
  logic                 osv_n, dv_n, err_n, replay;
  ordered_sets_e        ost_n;
  logic [DATA_SIZE-1:0] dout_n;

  always_comb begin
    state_n = state;
    coll_n  = coll;
    osv_n   = 1'b0;
    ost_n   = NONE;
    dv_n    = 1'b0;
    dout_n  = '0;
    err_n   = 1'b0;
    replay  = 1'b0;
    if (rx_valid) begin
      if (rx_code_err) begin
        err_n   = 1'b1;
        state_n = IDLE;
        if (state == GOT_K28_5) begin
          osv_n = 1'b1;
          ost_n = K;
        end
      end else begin
        case (state)
          IDLE: replay = 1'b1;
          GOT_K28_5:
            if (!rx_is_k && (rx_data == D10_2 || rx_data == D12_1 || rx_data == D08_7)) begin
              state_n = COLLECT1;
              coll_n  = rx_data;
            end else begin
              osv_n  = 1'b1;
              ost_n  = K;
              replay = 1'b1;
            end
          COLLECT1, COLLECT2:
            if (!rx_is_k && rx_data == coll) begin
              if (state == COLLECT1) state_n = COLLECT2;
              else begin
                state_n = IDLE;
                osv_n   = 1'b1;
                case (coll)
                  D10_2:   ost_n = SP;
                  D12_1:   ost_n = SPA;
                  default: ost_n = VER;
                endcase
              end
            end else begin
              err_n  = 1'b1;
              replay = 1'b1;
            end
          GOT_SCP1, GOT_ECP1, GOT_CC1:
            if (rx_is_k && state == GOT_SCP1 && rx_data == K27_7) begin
              state_n = IDLE; osv_n = 1'b1; ost_n = SCP;
            end else if (rx_is_k && state == GOT_ECP1 && rx_data == K30_7) begin
              state_n = IDLE; osv_n = 1'b1; ost_n = ECP;
            end else if (rx_is_k && state == GOT_CC1 && rx_data == K23_7) begin
              state_n = IDLE; osv_n = 1'b1; ost_n = CC;
            end else begin
              err_n  = 1'b1;
              replay = 1'b1;
            end
          default: state_n = IDLE;
        endcase
      end
      // Character re-examined as a fresh start. A pending K keeps the single os slot,
      // so a single-character code arriving right after a lone K28.5 is absorbed.
      if (replay) begin
        state_n = IDLE;
        if (!rx_is_k) begin
          dv_n   = 1'b1;
          dout_n = rx_data;
        end else begin
          case (rx_data)
            K28_5: state_n = GOT_K28_5;
            K28_2: state_n = GOT_SCP1;
            K29_7: state_n = GOT_ECP1;
            K23_7: state_n = GOT_CC1;
            K28_4, K28_0, K28_3, K28_6:
              if (!osv_n) begin
                osv_n = 1'b1;
                case (rx_data)
                  K28_4:   ost_n = P_SUF;
                  K28_0:   ost_n = R;
                  K28_3:   ost_n = A;
                  default: ost_n = SNF;
                endcase
              end
            default: err_n = 1'b1;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      coll       <= '0;
      os_valid   <= 1'b0;
      os_type    <= NONE;
      data_valid <= 1'b0;
      data_out   <= '0;
      os_err     <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      coll       <= coll_n;
      os_valid   <= osv_n;
      os_type    <= ost_n;
      data_valid <= dv_n;
      data_out   <= dout_n;
      os_err     <= err_n;
      if (err_n && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_aurora_ordered_set_detector.sv
// Bench for aurora_ordered_set_detector: directed vector table, corner sequences,
// and random character streams checked against a prefix-matching reference model.
module tb_aurora_ordered_set_detector;
  localparam logic [31:0] E_NONE = 32'h0, E_SP = 32'h4A4A4ABC, E_SPA = 32'h2C2C2CBC;
  localparam logic [31:0] E_VER = 32'hE8E8E8BC, E_SCP = 32'h0000FB5C, E_ECP = 32'h0000FEFD;
  localparam logic [31:0] E_CC = 32'h0000F7F7, E_K = 32'hBC, E_R = 32'h1C, E_A = 32'h7C;
  localparam logic [31:0] E_P = 32'h9C, E_SNF = 32'hDC;

  // {k, data}
  localparam logic [8:0] C_K285 = 9'h1BC, C_D102 = 9'h04A, C_D121 = 9'h02C, C_D087 = 9'h0E8;
  localparam logic [8:0] C_K282 = 9'h15C, C_K277 = 9'h1FB, C_K297 = 9'h1FD, C_K307 = 9'h1FE;
  localparam logic [8:0] C_K237 = 9'h1F7, C_K284 = 9'h19C, C_K280 = 9'h11C, C_K283 = 9'h17C;
  localparam logic [8:0] C_K286 = 9'h1DC, C_UNK = 9'h1FC;

  logic        clk = 1'b0, rst, rx_valid, rx_is_k, rx_code_err;
  logic [7:0]  rx_data, data_out, err_cnt;
  logic        os_valid, data_valid, os_err;
  logic [31:0] os_type;
  int passed = 0, total = 0;

  aurora_ordered_set_detector #(.DATA_SIZE(8), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_is_k(rx_is_k),
    .rx_code_err(rx_code_err), .os_valid(os_valid), .os_type(os_type),
    .data_valid(data_valid), .data_out(data_out), .os_err(os_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, limit 1000000 ns");
    $fatal(1);
  end

  typedef struct {
    logic v; logic [8:0] c; logic e;
    logic osv; logic [31:0] t; logic dv; logic [7:0] dout; logic err; logic [7:0] cnt;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(input logic v, input logic [8:0] c, input logic e,
                              input logic osv, input logic [31:0] t, input logic dv,
                              input logic [7:0] dout, input logic err, input logic [7:0] cnt);
    mk = '{v, c, e, osv, t, dv, dout, err, cnt};
  endfunction

  task automatic check(input string name, input logic eosv, input logic [31:0] et,
                       input logic edv, input logic [7:0] ed, input logic eerr,
                       input logic [7:0] ec);
    total++;
    if (os_valid === eosv && os_type === et && data_valid === edv && data_out === ed &&
        os_err === eerr && err_cnt === ec) passed++;
    else $display("FAIL %s: got osv=%b type=%h dv=%b dout=%h err=%b cnt=%0d, want osv=%b type=%h dv=%b dout=%h err=%b cnt=%0d",
                  name, os_valid, os_type, data_valid, data_out, os_err, err_cnt,
                  eosv, et, edv, ed, eerr, ec);
  endtask

  task automatic drive(input logic v, input logic [8:0] c, input logic e);
    @(negedge clk);
    rx_valid = v; rx_is_k = c[8]; rx_data = c[7:0]; rx_code_err = e;
    @(posedge clk);
    #1;
  endtask

  // Reference model: characters of an unfinished multi-character set are buffered in pend
  // and matched as prefixes against the table of defined sets.
  logic [35:0] seq_ch [6];
  int          seq_len[6];
  logic [31:0] seq_ty [6];
  logic [8:0]  sgl_ch [4];
  logic [31:0] sgl_ty [4];
  logic [8:0]  pool   [14];
  logic [8:0]  pend[$];
  int          m_cnt;
  logic        m_osv, m_dv, m_err;
  logic [31:0] m_type;
  logic [7:0]  m_dout;

  function automatic int seq_match(input logic [8:0] cand[$], output logic [31:0] t);
    int res = 0;
    t = E_NONE;
    for (int s = 0; s < 6; s++) begin
      if (cand.size() <= seq_len[s]) begin
        bit ok = 1'b1;
        for (int i = 0; i < cand.size(); i++)
          if (cand[i] !== seq_ch[s][i*9 +: 9]) ok = 1'b0;
        if (ok) begin
          if (cand.size() == seq_len[s]) begin t = seq_ty[s]; return 2; end
          res = 1;
        end
      end
    end
    return res;
  endfunction

  task automatic standalone(input logic [8:0] c);
    logic [8:0]  one[$];
    logic [31:0] t;
    if (!c[8]) begin m_dv = 1'b1; m_dout = c[7:0]; return; end
    for (int s = 0; s < 4; s++)
      if (c == sgl_ch[s]) begin
        if (!m_osv) begin m_osv = 1'b1; m_type = sgl_ty[s]; end
        return;
      end
    one.push_back(c);
    if (seq_match(one, t) == 1) pend = one;
    else m_err = 1'b1;
  endtask

  task automatic model_step(input logic v, input logic [8:0] c, input logic e);
    logic [8:0]  cand[$];
    logic [31:0] t;
    int          r;
    m_osv = 1'b0; m_type = E_NONE; m_dv = 1'b0; m_dout = 8'h0; m_err = 1'b0;
    if (!v) return;
    if (e) begin
      m_err = 1'b1;
      if (pend.size() == 1 && pend[0] == C_K285) begin m_osv = 1'b1; m_type = E_K; end
      pend.delete();
    end else begin
      cand = pend;
      cand.push_back(c);
      r = seq_match(cand, t);
      if (r == 2) begin m_osv = 1'b1; m_type = t; pend.delete(); end
      else if (r == 1) pend = cand;
      else begin
        if (pend.size() != 0) begin
          if (pend.size() == 1 && pend[0] == C_K285) begin m_osv = 1'b1; m_type = E_K; end
          else m_err = 1'b1;
          pend.delete();
        end
        standalone(c);
      end
    end
    if (m_err && m_cnt < 255) m_cnt++;
  endtask

  initial begin
    logic [8:0] stim[$];
    logic       v, e;
    logic [8:0] c;
    int         s, len, r;

    seq_ch[0] = {C_D102, C_D102, C_D102, C_K285}; seq_len[0] = 4; seq_ty[0] = E_SP;
    seq_ch[1] = {C_D121, C_D121, C_D121, C_K285}; seq_len[1] = 4; seq_ty[1] = E_SPA;
    seq_ch[2] = {C_D087, C_D087, C_D087, C_K285}; seq_len[2] = 4; seq_ty[2] = E_VER;
    seq_ch[3] = {18'h0, C_K277, C_K282};          seq_len[3] = 2; seq_ty[3] = E_SCP;
    seq_ch[4] = {18'h0, C_K307, C_K297};          seq_len[4] = 2; seq_ty[4] = E_ECP;
    seq_ch[5] = {18'h0, C_K237, C_K237};          seq_len[5] = 2; seq_ty[5] = E_CC;
    sgl_ch[0] = C_K284; sgl_ty[0] = E_P;
    sgl_ch[1] = C_K280; sgl_ty[1] = E_R;
    sgl_ch[2] = C_K283; sgl_ty[2] = E_A;
    sgl_ch[3] = C_K286; sgl_ty[3] = E_SNF;
    pool = '{C_K285, C_D102, C_D121, C_D087, C_K282, C_K277, C_K297,
             C_K307, C_K237, C_K284, C_K280, C_K283, C_K286, C_UNK};

    // SP
    vq.push_back(mk(1, C_K285, 0, 0, E_NONE, 0, 8'h00, 0, 0));
    vq.push_back(mk(1, C_D102, 0, 0, E_NONE, 0, 8'h00, 0, 0));
    vq.push_back(mk(1, C_D102, 0, 0, E_NONE, 0, 8'h00, 0, 0));
    vq.push_back(mk(1, C_D102, 0, 1, E_SP,   0, 8'h00, 0, 0));
    // SCP across idle cycles, then broken ECP
    vq.push_back(mk(1, C_K282, 0, 0, E_NONE, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 9'h000, 0, 0, E_NONE, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 9'h000, 0, 0, E_NONE, 0, 8'h00, 0, 0));
    vq.push_back(mk(1, C_K277, 0, 1, E_SCP,  0, 8'h00, 0, 0));
    vq.push_back(mk(1, C_K297, 0, 0, E_NONE, 0, 8'h00, 0, 0));
    vq.push_back(mk(1, 9'h055, 0, 0, E_NONE, 1, 8'h55, 1, 1));
    // lone K28.5 followed by data, repeated K28.5, then K28.0
    vq.push_back(mk(1, C_K285, 0, 0, E_NONE, 0, 8'h00, 0, 1));
    vq.push_back(mk(1, 9'h012, 0, 1, E_K,    1, 8'h12, 0, 1));
    vq.push_back(mk(1, C_K285, 0, 0, E_NONE, 0, 8'h00, 0, 1));
    vq.push_back(mk(1, C_K285, 0, 1, E_K,    0, 8'h00, 0, 1));
    vq.push_back(mk(1, C_K280, 0, 1, E_K,    0, 8'h00, 0, 1));
    vq.push_back(mk(1, C_K280, 0, 1, E_R,    0, 8'h00, 0, 1));
    // broken SPA
    vq.push_back(mk(1, C_K285, 0, 0, E_NONE, 0, 8'h00, 0, 1));
    vq.push_back(mk(1, C_D121, 0, 0, E_NONE, 0, 8'h00, 0, 1));
    vq.push_back(mk(1, C_D121, 0, 0, E_NONE, 0, 8'h00, 0, 1));
    vq.push_back(mk(1, C_D102, 0, 0, E_NONE, 1, 8'h4A, 1, 2));
    // CC, ECP, single codes, unknown K
    vq.push_back(mk(1, C_K237, 0, 0, E_NONE, 0, 8'h00, 0, 2));
    vq.push_back(mk(1, C_K237, 0, 1, E_CC,   0, 8'h00, 0, 2));
    vq.push_back(mk(1, C_K297, 0, 0, E_NONE, 0, 8'h00, 0, 2));
    vq.push_back(mk(1, C_K307, 0, 1, E_ECP,  0, 8'h00, 0, 2));
    vq.push_back(mk(1, C_K284, 0, 1, E_P,    0, 8'h00, 0, 2));
    vq.push_back(mk(1, C_K283, 0, 1, E_A,    0, 8'h00, 0, 2));
    vq.push_back(mk(1, C_K286, 0, 1, E_SNF,  0, 8'h00, 0, 2));
    vq.push_back(mk(1, C_K277, 0, 0, E_NONE, 0, 8'h00, 1, 3));
    // code error right after K28.5
    vq.push_back(mk(1, C_K285, 0, 0, E_NONE, 0, 8'h00, 0, 3));
    vq.push_back(mk(1, C_D102, 1, 1, E_K,    0, 8'h00, 1, 4));
    // VER, then SP broken by a single-character code
    vq.push_back(mk(1, C_K285, 0, 0, E_NONE, 0, 8'h00, 0, 4));
    vq.push_back(mk(1, C_D087, 0, 0, E_NONE, 0, 8'h00, 0, 4));
    vq.push_back(mk(1, C_D087, 0, 0, E_NONE, 0, 8'h00, 0, 4));
    vq.push_back(mk(1, C_D087, 0, 1, E_VER,  0, 8'h00, 0, 4));
    vq.push_back(mk(1, C_K285, 0, 0, E_NONE, 0, 8'h00, 0, 4));
    vq.push_back(mk(1, C_D102, 0, 0, E_NONE, 0, 8'h00, 0, 4));
    vq.push_back(mk(1, C_K283, 0, 1, E_A,    0, 8'h00, 1, 5));

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_is_k = 1'b0; rx_code_err = 1'b0;
    #12;
    check("reset", 0, E_NONE, 0, 8'h00, 0, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].c, vq[i].e);
      check($sformatf("vec%0d", i), vq[i].osv, vq[i].t, vq[i].dv, vq[i].dout, vq[i].err, vq[i].cnt);
    end

    // asynchronous reset in the middle of a VER
    drive(1, C_K285, 0);
    check("mid_k285", 0, E_NONE, 0, 8'h00, 0, 8'd5);
    drive(1, C_D087, 0);
    check("mid_d087", 0, E_NONE, 0, 8'h00, 0, 8'd5);
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst_async", 0, E_NONE, 0, 8'h00, 0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, C_D087, 0);
    check("post_rst_d0", 0, E_NONE, 1, 8'hE8, 0, 8'd0);
    drive(1, C_D087, 0);
    check("post_rst_d1", 0, E_NONE, 1, 8'hE8, 0, 8'd0);

    // error counter saturation
    repeat (300) drive(1, C_UNK, 0);
    check("sat", 0, E_NONE, 0, 8'h00, 1, 8'd255);
    drive(1, C_UNK, 0);
    check("sat_hold", 0, E_NONE, 0, 8'h00, 1, 8'd255);
    drive(1, C_K284, 0);
    check("sat_psuf", 1, E_P, 0, 8'h00, 0, 8'd255);

    // random streams against the model
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pend.delete();
    m_cnt = 0;
    for (int n = 0; n < 2000; n++) begin
      if (stim.size() == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          s   = $urandom_range(0, 5);
          len = seq_len[s];
          if ($urandom_range(0, 4) == 0) len = $urandom_range(1, len);
          for (int i = 0; i < len; i++) stim.push_back(seq_ch[s][i*9 +: 9]);
        end else begin
          r = $urandom_range(0, 17);
          if (r < 14) stim.push_back(pool[r]);
          else stim.push_back({1'b0, 8'($urandom)});
        end
      end
      v = ($urandom_range(0, 9) < 8);
      e = ($urandom_range(0, 59) == 0);
      c = v ? stim.pop_front() : 9'h000;
      drive(v, c, e);
      model_step(v, c, e);
      check($sformatf("rand%0d", n), m_osv, m_type, m_dv, m_dout, m_err, 8'(m_cnt));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
